// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one logic/ALU unit between NREQ requesters.
// A pending request is granted, and its operands and opcode are registered
// onto the shared unit. The block then waits LU_LAT cycles, captures the
// result, and returns it on a valid/ready channel tagged with the requester
// index. Only one operation is in flight at a time.
//
// Build option: define LUARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority (lowest index wins).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (grant is one-hot)
//   req_a/req_b/req_op    packed per-requester operands and opcode
//   lu_a/lu_b/lu_op       registered operands and opcode to the shared unit
//   lu_busy               unit computing
//   lu_res                shared-unit result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data       owner index and captured result
module logic_unit_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int LU_LAT = 1,
  parameter int IDW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [WIDTH-1:0]      lu_a,
  output logic [WIDTH-1:0]      lu_b,
  output logic [1:0]            lu_op,
  output logic                  lu_busy,
  input  logic [WIDTH-1:0]      lu_res,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int          IXW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U   = NREQ;
  localparam logic [3:0]  CNT_LOAD = 4'(LU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic [1:0]       lu_op_q, lu_op_d;
  logic             lu_busy_q, lu_busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef LUARB_RR_EN
  logic [IXW-1:0]   ptr_q, ptr_d;
`endif

  logic             gnt_found;
  logic [IXW-1:0]   gnt_idx;
  int unsigned      cand;
  logic             xfer;

  // Grant search: a linear scan, starting at the pointer when round-robin
  // is enabled, or at index 0 otherwise.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
`ifdef LUARB_RR_EN
      cand = 32'(ptr_q) + k;
      if (cand >= NREQ_U) begin
        cand = cand - NREQ_U;
      end
`else
      cand = k;
`endif
      if (!gnt_found && req_valid[cand[IXW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IXW-1:0];
      end
    end
  end

  assign xfer = (state_q == ST_IDLE) && gnt_found;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lu_a_q      <= '0;
      lu_b_q      <= '0;
      lu_op_q     <= '0;
      lu_busy_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef LUARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_op_q     <= lu_op_d;
      lu_busy_q   <= lu_busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef LUARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (xfer && rst_n) begin
      req_ready[gnt_idx] = 1'b1;
    end

    lu_a_d     = lu_a_q;
    lu_b_d     = lu_b_q;
    lu_op_d    = lu_op_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
`ifdef LUARB_RR_EN
    ptr_d      = ptr_q;
`endif

    if (xfer) begin
      lu_a_d   = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
      lu_b_d   = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
      lu_op_d  = req_op[32'(gnt_idx)*2 +: 2];
      rsp_id_d = IDW'(gnt_idx);
`ifdef LUARB_RR_EN
      ptr_d    = (32'(gnt_idx) == NREQ_U - 1) ? '0 : gnt_idx + IXW'(1);
`endif
    end

    if (state_q == ST_BUSY && cnt_q == '0) begin
      rsp_data_d = lu_res;
    end

    // Status flags are registered from the next state so both come
    // straight from flops.
    lu_busy_d   = (state_d == ST_BUSY);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_op     = lu_op_q;
  assign lu_busy   = lu_busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
